// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the buffered write-back entry type.
package wb_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO; pointers wrap modulo DEPTH, a count register separates full from empty.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and buffered load results into one register-file write per cycle.
// Optional WB_BYPASS_EN adds same-cycle forwarding of the write being performed.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data
`ifdef WB_BYPASS_EN
    ,
    output logic                  rs1_fwd_valid,
    output logic                  rs2_fwd_valid,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic [XLEN-1:0]       rs2_fwd_data
`endif
);
    localparam int EW = REG_ADDR_W + XLEN;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [EW-1:0]         head;
    logic                  full, empty, push, pop, wr_en;
    logic [CW-1:0]         count;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic [31:0]           pending, set_mask, clr_mask;

    assign mem_ready = count < CW'(FIFO_DEPTH);
    assign push      = mem_valid & ~full;
    assign pop       = ~alu_valid & ~empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({mem_rd, mem_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // x0 entries are still consumed, they just never raise a write
    always_comb begin
        sel_rd   = alu_valid ? alu_rd : head[EW-1 -: REG_ADDR_W];
        sel_data = alu_valid ? alu_data : head[XLEN-1:0];
        wr_en    = (alu_valid | ~empty) & (sel_rd != '0);
        clr_mask = wr_en ? 32'(1) << sel_rd : '0;
        set_mask = (issue_valid && issue_rd != '0) ? 32'(1) << issue_rd : '0;
    end

    // OR-ing the set after the clear lets a fresh issue win over a completing write
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            pending  <= '0;
        end else begin
            RegWrite <= wr_en;
            rd_addr  <= sel_rd;
            rd_data  <= sel_data;
            pending  <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign rs1_pending = pending[chk_rs1];
    assign rs2_pending = pending[chk_rs2];

`ifdef WB_BYPASS_EN
    assign rs1_fwd_valid = RegWrite && rd_addr == chk_rs1 && chk_rs1 != '0;
    assign rs2_fwd_valid = RegWrite && rd_addr == chk_rs2 && chk_rs2 != '0;
    assign rs1_fwd_data  = rd_data;
    assign rs2_fwd_data  = rd_data;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed self-checking bench for writeback_unit.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd, chk_rs1, chk_rs2;
    logic [31:0] alu_data, mem_data;
    logic        mem_ready, rs1_pending, rs2_pending, RegWrite;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef WB_BYPASS_EN
    logic        rs1_fwd_valid, rs2_fwd_valid;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .RegWrite    (RegWrite),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`ifdef WB_BYPASS_EN
        ,
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
    endtask

    initial begin
        reset = 1; idle();
        alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0;
        issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        step(); step();
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_pending", rs1_pending, 0);
        reset = 0;

        // issue rd=5, then ALU completes it
        issue_valid = 1; issue_rd = 5; chk_rs1 = 5;
        step();
        chk("pend5_set", rs1_pending, 1);
        issue_valid = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        chk("pend5_hold", rs1_pending, 1);
        step();
        chk("alu_we", RegWrite, 1);
        chk("alu_addr", rd_addr, 5);
        chk("alu_data", rd_data, 32'hDEADBEEF);
        chk("pend5_clr", rs1_pending, 0);
        idle();
        step();
        chk("alu_idle", RegWrite, 0);

        // loads held off by continuous ALU traffic
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 3; alu_data = 32'h100 + i;
            mem_valid = 1; mem_rd = 7; mem_data = 32'h1234 + i;
            chk($sformatf("ready_%0d", i), mem_ready, (i < 4) ? 1 : 0);
            step();
            chk($sformatf("busy_addr_%0d", i), rd_addr, 3);
            chk($sformatf("busy_data_%0d", i), rd_data, 32'h100 + i);
        end
        idle();
        chk("full_ready", mem_ready, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ld_we_%0d", k), RegWrite, 1);
            chk($sformatf("ld_addr_%0d", k), rd_addr, 7);
            chk($sformatf("ld_data_%0d", k), rd_data, 32'h1234 + k);
            chk($sformatf("ld_ready_%0d", k), mem_ready, 1);
        end
        step();
        chk("drained_we", RegWrite, 0);

        // x0 destinations from both sources
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        mem_valid = 1; mem_rd = 0; mem_data = 32'hEEEE;
        step();
        chk("x0_alu_we", RegWrite, 0);
        idle();
        step();
        chk("x0_ld_we", RegWrite, 0);
        step();
        chk("x0_empty_we", RegWrite, 0);
        chk("x0_ready", mem_ready, 1);
        mem_valid = 1; mem_rd = 8; mem_data = 32'h88;
        step();
        idle();
        step();
        chk("post_x0_we", RegWrite, 1);
        chk("post_x0_addr", rd_addr, 8);
        chk("post_x0_data", rd_data, 32'h88);
        issue_valid = 1; issue_rd = 0; chk_rs1 = 0;
        step();
        idle();
        chk("x0_never_pending", rs1_pending, 0);

        // set wins over same-edge clear
        issue_valid = 1; issue_rd = 9; chk_rs1 = 9;
        step();
        chk("pend9_set", rs1_pending, 1);
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        step();
        chk("pend9_we", RegWrite, 1);
        chk("pend9_addr", rd_addr, 9);
        chk("pend9_setwins", rs1_pending, 1);
        issue_valid = 0;
        step();
        chk("pend9_clr", rs1_pending, 0);
        idle();
        step();

        // reset with buffered loads and pending bits
        issue_valid = 1; issue_rd = 4; chk_rs1 = 4; chk_rs2 = 6;
        step();
        issue_rd = 6;
        step();
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 3; alu_data = 32'h0;
            mem_valid = 1; mem_rd = 5'(10 + i); mem_data = 32'h500 + i;
            step();
        end
        chk("pre_rst_p4", rs1_pending, 1);
        chk("pre_rst_p6", rs2_pending, 1);
        idle(); reset = 1;
        step();
        chk("mid_rst_we", RegWrite, 0);
        chk("mid_rst_ready", mem_ready, 1);
        chk("mid_rst_p4", rs1_pending, 0);
        chk("mid_rst_p6", rs2_pending, 0);
        reset = 0;
        step();
        chk("post_rst_we", RegWrite, 0);

`ifdef WB_BYPASS_EN
        alu_valid = 1; alu_rd = 12; alu_data = 32'hA5A5; chk_rs2 = 12; chk_rs1 = 3;
        step();
        idle();
        chk("fwd2_valid", rs2_fwd_valid, 1);
        chk("fwd2_data", rs2_fwd_data, 32'hA5A5);
        chk("fwd1_miss", rs1_fwd_valid, 0);
        chk_rs2 = 0;
        #1;
        chk("fwd2_x0", rs2_fwd_valid, 0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Collects completed results from the single-cycle ALU path and the variable-latency load path and sequences them into the 32-entry register file, one write per cycle, through the `RegWrite`/`rd_addr`/`rd_data` write port. Load results are buffered in a small FIFO so the memory side never blocks the ALU. A 32-bit pending scoreboard lets the issue stage see which destination registers still have writes outstanding. The block sits between the execute/memory stages and `register_file`.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `FIFO_DEPTH`, default 4: load-result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no backpressure.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  load result accepted when `mem_valid & mem_ready`.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  XLEN  load result.
- `issue_valid`  in  1  an instruction writing `issue_rd` is issued.
- `issue_rd`  in  5  destination to mark pending.
- `chk_rs1`, `chk_rs2`  in  5 each  source registers to query.
- `rs1_pending`, `rs2_pending`  out  1 each  combinational `pending[chk_rsN]`; always 0 for x0.
- `RegWrite`  out  1  register file write enable (registered).
- `rd_addr`  out  5  write address (registered).
- `rd_data`  out  XLEN  write data (registered).
- `rs1_fwd_valid`, `rs2_fwd_valid`  out  1 each  present only with `WB_BYPASS_EN`.
- `rs1_fwd_data`, `rs2_fwd_data`  out  XLEN each  present only with `WB_BYPASS_EN`.

## Operation
- Reset: FIFO empty, `pending` = 0, `RegWrite`/`rd_addr`/`rd_data` = 0, `mem_ready` = 1.
- Each cycle exactly one source is selected into the output register:
  - ALU, if `alu_valid`.
  - Otherwise the FIFO head, if the FIFO is non-empty; the head is popped.
  - Otherwise nothing, and `RegWrite` = 0 next cycle.
- `mem_ready` = (count < FIFO_DEPTH), computed from registered count only. A full FIFO refuses a push even in a cycle that pops.
- Destination x0: the entry is consumed (FIFO pop / ALU accept) but `RegWrite` stays 0 and the scoreboard is untouched.
- Scoreboard clear: `pending[rd]` clears on the same edge the output register loads a write to `rd != 0`.
- Scoreboard set: `issue_valid & issue_rd != 0` sets `pending[issue_rd]`.
- Set and clear of the same register on the same edge: set wins, because the newer issue is outstanding.
- Duplicate set of an already pending register is legal. The scoreboard is not a counter, so the issue stage must not issue a second writer to a pending rd.
- Reset mid-operation discards FIFO contents and all pending bits, and deasserts `RegWrite` on the next edge.

## Timing
- ALU result at cycle N: `RegWrite`, `rd_addr`, `rd_data` valid in cycle N+1.
- Load accepted at cycle N into an empty FIFO, no ALU result at N+1: `RegWrite` in cycle N+2.
- While ALU results arrive every cycle, the FIFO does not drain. With FIFO_DEPTH held loads, `mem_ready` = 0 until the first cycle without `alu_valid`; `mem_ready` returns to 1 one cycle after the pop.
- Throughput: one register write per cycle maximum.
- `rsN_pending` is combinational from the current `pending` register. It reflects a clear in the same cycle `RegWrite` is high.

## Configuration
- `WB_BYPASS_EN` defined: adds the `rsN_fwd_*` ports.
  - `rsN_fwd_valid = RegWrite & rd_addr == chk_rsN & chk_rsN != 0`.
  - `rsN_fwd_data = rd_data`.
  - Lets consumers use a result in the cycle it is being written.
- Undefined: ports absent and no forwarding logic. Consumers read the register file the cycle after `RegWrite`.

## Structure
- Package `wb_pkg`:
  - `REG_ADDR_W = 5`
  - `XLEN_DEFAULT = 32`
  - typedef `wb_entry_t` {rd, data}
- Sub-module `wb_fifo`: synchronous FIFO parameterised on depth and entry width.
  - Interface: push/pop/full/empty/count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Wrap/full/empty are distinguished by a count register.
- Top: selection mux, output register, scoreboard, optional bypass.

## Test plan
- Reset, then ALU (rd=5, 0xDEADBEEF) at cycle 1 → cycle 2: `RegWrite`=1, `rd_addr`=5, `rd_data`=0xDEADBEEF; issue rd=5 at cycle 0 gives `rs1_pending`(5)=1 through cycle 1 and 0 at cycle 2.
- Load (rd=7, 0x1234) with an ALU (rd=3) every cycle for 6 cycles → 4 loads accepted, `mem_ready`=0 afterwards, no load writes until the ALU stops; loads then write in order one per cycle.
- ALU and load both with rd=0 → `RegWrite` never asserts, FIFO count returns to 0.
- `issue_valid` rd=9 on the same edge a write to rd=9 completes → `pending[9]` remains 1.
- Reset asserted with 3 loads buffered and pending bits {4,6} → next cycle FIFO empty, `mem_ready`=1, `pending`=0, `RegWrite`=0.
- With `WB_BYPASS_EN`: `chk_rs2`=12 while writing rd=12 data 0xA5A5 → `rs2_fwd_valid`=1, `rs2_fwd_data`=0xA5A5; with `chk_rs2`=0, `rs2_fwd_valid`=0.
